arb_requester: RTL

//  Client-side companion to the 3-way fixed-priority arbiter: one instance per requester line (r1/r2/r3).

---
 rtl/arb_pkg.sv | 16 +
 rtl/arb_requester_if.sv | 26 ++
 rtl/arb_wait_timer.sv | 27 ++
 rtl/arb_requester.sv | 126 ++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the fixed-priority arbiter and its requester clients.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_XFER = 2'b10,
        ST_HOLD = 2'b11
    } arb_state_e;

    // Bits needed for a counter that must reach n-1 (at least 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_requester_if.sv
// Job/handshake bundle between one requester and its environment (job source, arbiter, sink).
interface arb_requester_if #(
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             grant;
    logic             stall;
    logic             req;
    logic             busy;
    logic             beat;
    logic [LEN_W-1:0] beat_idx;
    logic             done;
    logic             timeout;

    // master: the requester itself; slave: whatever drives jobs and grants.
    modport master (
        input  start, len, grant, stall,
        output req, busy, beat, beat_idx, done, timeout
    );

    modport slave (
        output start, len, grant, stall,
        input  req, busy, beat, beat_idx, done, timeout
    );
endinterface

// File: rtl/arb_wait_timer.sv
// Clearable up-counter with a terminal-count flag.
module arb_wait_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_term
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_term = (r_count == i_term);

endmodule

// File: rtl/arb_requester.sv
// Requester client for the 3-way fixed-priority arbiter: requests, streams N beats while
// granted, then backs off for HOLDOFF cycles; aborts if the grant never comes.
module arb_requester
    import arb_pkg::*;
#(
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned TO_W    = 8,
    parameter int unsigned TIMEOUT = 200,
    parameter int unsigned HOLDOFF = 2
) (
    input  logic      clk,
    input  logic      reset,
    arb_requester_if.master bus
);

    localparam int unsigned      HO_W    = cnt_width(HOLDOFF);
    localparam logic [TO_W-1:0]  TO_TERM = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);
    localparam logic [HO_W-1:0]  HO_TERM = HO_W'(HOLDOFF - 1);

    arb_state_e       r_state;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_beat_idx;
    logic             r_req;
    logic             r_busy;
    logic             r_done;
    logic             r_timeout;

    logic w_beat;
    logic w_last;
    logic w_to_clr;
    logic w_to_en;
    logic w_to_term;
    logic w_to_fire;
    logic w_ho_clr;
    logic w_ho_term;

    assign w_beat    = (r_state == ST_XFER) && bus.grant && !bus.stall;
    assign w_last    = w_beat && (r_beat_idx == r_len - LEN_W'(1));

    // Both timers sit at zero outside their state, so each entry starts a fresh count.
    assign w_to_clr  = (r_state != ST_REQ);
    assign w_to_en   = (r_state == ST_REQ) && !bus.grant;
    assign w_to_fire = (TIMEOUT != 0) && w_to_term;
    assign w_ho_clr  = (r_state != ST_HOLD);

    arb_wait_timer #(.W(TO_W)) u_grant_timer (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_to_clr),
        .i_en   (w_to_en),
        .i_term (TO_TERM),
        .o_term (w_to_term)
    );

    arb_wait_timer #(.W(HO_W)) u_hold_timer (
        .clk    (clk),
        .rst_n  (reset),
        .i_clr  (w_ho_clr),
        .i_en   (1'b1),
        .i_term (HO_TERM),
        .o_term (w_ho_term)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_len      <= '0;
            r_beat_idx <= '0;
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && (bus.len != '0)) begin
                        r_len      <= bus.len;
                        r_beat_idx <= '0;
                        r_req      <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.grant) begin
                        r_state <= ST_XFER;
                    end else if (w_to_fire) begin
                        r_req     <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= ST_HOLD;
                    end
                end
                ST_XFER: begin
                    // Losing grant mid-job keeps beat_idx so the job resumes on regrant.
                    if (!bus.grant) begin
                        r_state <= ST_REQ;
                    end else if (w_last) begin
                        r_req      <= 1'b0;
                        r_done     <= 1'b1;
                        r_beat_idx <= '0;
                        r_state    <= ST_HOLD;
                    end else if (w_beat) begin
                        r_beat_idx <= r_beat_idx + LEN_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (w_ho_term) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req      = r_req;
    assign bus.busy     = r_busy;
    assign bus.beat     = w_beat;
    assign bus.beat_idx = r_beat_idx;
    assign bus.done     = r_done;
    assign bus.timeout  = r_timeout;

endmodule
